eu_barrier_wait_ctrl: RTL and testbench
=======================================

# eu_barrier_wait_ctrl

Per-core trigger-and-sleep controller that sits directly upstream and downstream of the hardware barrier unit in the event unit. A core issues one read to a "wait on barrier b" address. The block then pulses that core's trigger line to barrier b, gates the core clock, and buffers barrier events so none are lost. The stalled read completes when barrier b's event for that core arrives; that completion is the core's wake-up.

## Interface
- NB_CORES, default 4: number of cores; one FSM per core.
- NB_BARR, default 2: number of barrier units served; must be ≤ 63.
- TIMEOUT_W, default 16: timeout counter width; used only with the timeout macro.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- core_req_i  in  [NB_CORES]  per-core request from the demuxed core port.
- core_wen_i  in  [NB_CORES]  1 = read, 0 = write.
- core_add_i  in  [NB_CORES][7:0]  byte offset; bits [7:2] are decoded.
- core_wdata_i  in  [NB_CORES][31:0]  write data.
- core_gnt_o  out  [NB_CORES]  grant.
- core_r_valid_o  out  [NB_CORES]  response valid.
- core_r_rdata_o  out  [NB_CORES][31:0]  response data.
- barrier_trigger_o  out  [NB_BARR][NB_CORES]  trigger pulses to the barrier units.
- barrier_events_i  in  [NB_BARR][NB_CORES]  barrier event inputs; each is a one-cycle pulse.
- core_clock_en_o  out  [NB_CORES]  core clock-gate enable.

## Operation
- Address decode, using idx = add[7:2]:
  - Read with idx < NB_BARR: WAIT on barrier idx.
  - idx = 6'h3F, read: returns the core's pending mask in rdata[NB_BARR-1:0].
  - idx = 6'h3F, write: clears the pending bits selected by wdata[NB_BARR-1:0].
  - Any other access: reads return 0, writes are ignored.
- Pending buffer pend[b][c]:
  - Set on barrier_events_i[b][c].
  - Cleared on consumption by a WAIT, or by a masked clear write.
  - An event and a clear on the same bit in the same cycle: the set wins.
- Per-core FSM states: IDLE, TRIG, SLEEP, WAKE.
  - IDLE: gnt = 1.
    - Granted WAIT: latch b, go to TRIG.
    - Any other access: r_valid the next cycle, stay in IDLE.
  - TRIG: gnt = 0; barrier_trigger_o[b][c] = 1 for exactly this cycle; go to SLEEP.
  - SLEEP: gnt = 0; core_clock_en_o = 0.
    - wake = pend[b][c] | barrier_events_i[b][c].
    - When wake is true: go to WAKE and clear pend[b][c]. An event consumed this way never sets pend.
  - WAKE: clock_en = 1; r_valid = 1; rdata = {1'b0, 23'b0, b[7:0]}; go to IDLE.
- Events for barriers the core is not waiting on are buffered, not dropped.
- Cores are fully independent; no arbitration is needed.

## Timing
- Reset values:
  - core_gnt_o = 1 (all cores in IDLE).
  - core_r_valid_o = 0.
  - core_r_rdata_o = 0.
  - barrier_trigger_o = 0.
  - core_clock_en_o = all 1.
  - pend = 0.
- Reset mid-SLEEP: clock_en returns to 1 asynchronously and the FSM goes to IDLE. The outstanding response is dropped.
- WAIT accepted in cycle t:
  - Trigger is asserted at t+1.
  - SLEEP from t+2.
  - An event at cycle e ≥ t+2 gives r_valid at e+1.
  - Minimum WAIT latency is 3 cycles, with the event at t+2.
- An event already pending, or arriving at t or t+1, is captured in pend and consumed at the first SLEEP cycle (t+2), so r_valid is at t+3.
- Non-WAIT accesses: gnt in the same cycle, r_valid one cycle later. A clear write takes effect at t+1.
- The trigger pulse is exactly 1 cycle per WAIT and is never repeated.

## Configuration
- BARRIER_WAIT_TIMEOUT_EN defined:
  - A per-core TIMEOUT_W-bit counter clears on entry to SLEEP and increments each SLEEP cycle.
  - At all-ones, the core goes to WAKE with rdata[31] = 1.
  - pend[b][c] is left untouched.
  - A wake condition and the timeout in the same cycle: the event wins, and rdata[31] = 0.
- BARRIER_WAIT_TIMEOUT_EN undefined: no counter; a core sleeps indefinitely and rdata[31] is always 0.

## Structure
- Package eu_barrier_pkg:
  - State enum.
  - Offset constant for the pending/clear register (6'h3F).
  - rdata field positions: error bit 31, id [7:0].
- Sub-module eu_barrier_wait_fsm: one core's FSM, optional timeout counter and response logic.
  - Instantiated NB_CORES times with a generate loop.
  - The pend array and decode stay in the top level.

## Test plan
- Basic wait: core 0 WAITs on barrier 0 at t; event[0][0] pulsed at t+5.
  - Trigger[0][0] high only at t+1.
  - clock_en[0] = 0 for t+2..t+5.
  - r_valid at t+6 with rdata 0x0.
- Early event: event[1][2] pulsed first; core 2 then WAITs on barrier 1.
  - Pending mask reads 0b10 before the WAIT.
  - r_valid at t+3, with clock_en low for one cycle only.
  - Pending mask reads 0 afterwards.
- Foreign event: core 1 waits on barrier 0 and event[1][1] arrives.
  - Core stays in SLEEP.
  - pend[1][1] = 1.
  - A later event[0][1] wakes the core; pend[1][1] is still 1.
- Clear race: write wdata 0x1 to 6'h3F in the same cycle that event[0][3] pulses → pend[0][3] = 1.
- Reset in SLEEP: assert rst_ni low while core 0 sleeps.
  - clock_en[0] = 1 immediately, no r_valid.
  - A post-reset WAIT behaves normally.
- Timeout (macro defined, TIMEOUT_W = 4): WAIT with no event → r_valid with rdata = 0x8000_0000 plus id, 15 SLEEP cycles after SLEEP entry.

Source files
------------

// File: rtl/eu_barrier_pkg.sv
// Shared types and constants for the event-unit barrier wait controller.
// Holds the per-core FSM state encoding and the wake response layout.
package eu_barrier_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRIG  = 2'd1,
        SLEEP = 2'd2,
        WAKE  = 2'd3
    } wait_state_e;

    localparam logic [5:0] PEND_REG_IDX = 6'h3F;

    localparam int RDATA_ERR_BIT = 31;
    localparam int RDATA_ID_MSB  = 7;
    localparam int RDATA_ID_LSB  = 0;

    function automatic logic [31:0] wake_rdata(input logic err, input logic [5:0] id);
        logic [31:0] d;
        d = '0;
        d[RDATA_ERR_BIT] = err;
        d[RDATA_ID_MSB:RDATA_ID_LSB] = {2'b00, id};
        return d;
    endfunction

endpackage

// File: rtl/eu_barrier_wait_fsm.sv
// One core's trigger/sleep/wake sequencer plus its response register.
// The optional sleep timeout is built only when BARRIER_WAIT_TIMEOUT_EN is defined.
module eu_barrier_wait_fsm
    import eu_barrier_pkg::*;
#(
    parameter int TIMEOUT_W = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        wait_i,
    input  logic [5:0]  wait_id_i,
    input  logic [31:0] rd_data_i,
    input  logic        wake_i,
    output logic        gnt_o,
    output logic        trigger_o,
    output logic [5:0]  barr_id_o,
    output logic        clock_en_o,
    output logic        consume_o,
    output logic        r_valid_o,
    output logic [31:0] r_rdata_o
);

    wait_state_e state_q, state_d;
    logic [5:0]  id_q, id_d;
    logic        err_q, err_d;
    logic        resp_vld_q, resp_vld_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        timeout;

`ifdef BARRIER_WAIT_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] cnt_q;

    // Counter is zeroed during TRIG so it reads 0 on the first SLEEP cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (state_q == TRIG) begin
            cnt_q <= '0;
        end else if (state_q == SLEEP) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign timeout = (state_q == SLEEP) && (&cnt_q);
`else
    logic [TIMEOUT_W-1:0] tmo_unused;
    assign tmo_unused = '0;
    assign timeout    = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            id_q        <= '0;
            err_q       <= 1'b0;
            resp_vld_q  <= 1'b0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            err_q       <= err_d;
            resp_vld_q  <= resp_vld_d;
            resp_data_q <= resp_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        err_d       = err_q;
        resp_vld_d  = 1'b0;
        resp_data_d = '0;
        gnt_o       = 1'b0;
        trigger_o   = 1'b0;
        clock_en_o  = 1'b1;
        consume_o   = 1'b0;

        case (state_q)
            IDLE: begin
                gnt_o = 1'b1;
                if (req_i) begin
                    if (wait_i) begin
                        id_d    = wait_id_i;
                        err_d   = 1'b0;
                        state_d = TRIG;
                    end else begin
                        resp_vld_d  = 1'b1;
                        resp_data_d = rd_data_i;
                    end
                end
            end
            TRIG: begin
                trigger_o = 1'b1;
                state_d   = SLEEP;
            end
            SLEEP: begin
                clock_en_o = 1'b0;
                // A real wake takes priority over a simultaneous timeout.
                if (wake_i) begin
                    consume_o = 1'b1;
                    state_d   = WAKE;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = WAKE;
                end
            end
            WAKE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign barr_id_o = id_q;
    assign r_valid_o = resp_vld_q | (state_q == WAKE);
    assign r_rdata_o = (state_q == WAKE) ? wake_rdata(err_q, id_q) : resp_data_q;

endmodule

// File: rtl/eu_barrier_wait_ctrl.sv
// Per-core barrier trigger-and-sleep controller with a buffered pending-event array.
// Optional sleep timeout enabled by defining BARRIER_WAIT_TIMEOUT_EN.
module eu_barrier_wait_ctrl
    import eu_barrier_pkg::*;
#(
    parameter int NB_CORES  = 4,
    parameter int NB_BARR   = 2,
    parameter int TIMEOUT_W = 16
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NB_CORES-1:0]                core_req_i,
    input  logic [NB_CORES-1:0]                core_wen_i,
    input  logic [NB_CORES-1:0][7:0]           core_add_i,
    input  logic [NB_CORES-1:0][31:0]          core_wdata_i,
    output logic [NB_CORES-1:0]                core_gnt_o,
    output logic [NB_CORES-1:0]                core_r_valid_o,
    output logic [NB_CORES-1:0][31:0]          core_r_rdata_o,
    output logic [NB_BARR-1:0][NB_CORES-1:0]   barrier_trigger_o,
    input  logic [NB_BARR-1:0][NB_CORES-1:0]   barrier_events_i,
    output logic [NB_CORES-1:0]                core_clock_en_o
);

    logic [NB_CORES-1:0]              wait_req;
    logic [NB_CORES-1:0]              fsm_gnt;
    logic [NB_CORES-1:0]              trig;
    logic [NB_CORES-1:0]              consume;
    logic [NB_CORES-1:0]              wake;
    logic [NB_CORES-1:0][5:0]         barr_id;
    logic [NB_CORES-1:0][31:0]        rd_data;
    logic [NB_BARR-1:0][NB_CORES-1:0] pend_q;
    logic [NB_BARR-1:0][NB_CORES-1:0] clr_mask;
    logic [5:0]                       idx;
    logic                             unused_bits;

    assign unused_bits = ^{core_add_i, core_wdata_i};

    // Address decode: WAIT reads, pending-mask reads and masked clear writes.
    always_comb begin
        wait_req = '0;
        rd_data  = '0;
        clr_mask = '0;
        idx      = '0;
        for (int c = 0; c < NB_CORES; c++) begin
            idx = core_add_i[c][7:2];
            if (core_wen_i[c] && ({1'b0, idx} < 7'(NB_BARR))) begin
                wait_req[c] = 1'b1;
            end
            if (core_wen_i[c] && (idx == PEND_REG_IDX)) begin
                for (int b = 0; b < NB_BARR; b++) begin
                    rd_data[c][b] = pend_q[b][c];
                end
            end
            if (core_req_i[c] && fsm_gnt[c] && !core_wen_i[c] && (idx == PEND_REG_IDX)) begin
                for (int b = 0; b < NB_BARR; b++) begin
                    clr_mask[b][c] = core_wdata_i[c][b];
                end
            end
        end
    end

    always_comb begin
        wake              = '0;
        barrier_trigger_o = '0;
        for (int c = 0; c < NB_CORES; c++) begin
            for (int b = 0; b < NB_BARR; b++) begin
                if (barr_id[c] == 6'(b)) begin
                    wake[c] = wake[c] | pend_q[b][c] | barrier_events_i[b][c];
                    barrier_trigger_o[b][c] = trig[c];
                end
            end
        end
    end

    // Consumption beats everything; otherwise a new event beats a clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= '0;
        end else begin
            for (int b = 0; b < NB_BARR; b++) begin
                for (int c = 0; c < NB_CORES; c++) begin
                    if (consume[c] && (barr_id[c] == 6'(b))) begin
                        pend_q[b][c] <= 1'b0;
                    end else begin
                        pend_q[b][c] <= (pend_q[b][c] & ~clr_mask[b][c]) | barrier_events_i[b][c];
                    end
                end
            end
        end
    end

    for (genvar c = 0; c < NB_CORES; c++) begin : g_core
        eu_barrier_wait_fsm #(
            .TIMEOUT_W (TIMEOUT_W)
        ) u_fsm (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .req_i      (core_req_i[c]),
            .wait_i     (wait_req[c]),
            .wait_id_i  (core_add_i[c][7:2]),
            .rd_data_i  (rd_data[c]),
            .wake_i     (wake[c]),
            .gnt_o      (fsm_gnt[c]),
            .trigger_o  (trig[c]),
            .barr_id_o  (barr_id[c]),
            .clock_en_o (core_clock_en_o[c]),
            .consume_o  (consume[c]),
            .r_valid_o  (core_r_valid_o[c]),
            .r_rdata_o  (core_r_rdata_o[c])
        );
    end

    assign core_gnt_o = fsm_gnt;

endmodule

// File: tb/tb_eu_barrier_wait_ctrl.sv
// Directed self-checking bench for eu_barrier_wait_ctrl (4 cores, 2 barriers).
// Adds a timeout scenario when BARRIER_WAIT_TIMEOUT_EN is defined.
module tb_eu_barrier_wait_ctrl;

`ifdef BARRIER_WAIT_TIMEOUT_EN
    localparam int TW = 4;
`else
    localparam int TW = 16;
`endif

    logic             clk;
    logic             rst_ni;
    logic [3:0]       core_req;
    logic [3:0]       core_wen;
    logic [3:0][7:0]  core_add;
    logic [3:0][31:0] core_wdata;
    logic [3:0]       core_gnt;
    logic [3:0]       core_r_valid;
    logic [3:0][31:0] core_r_rdata;
    logic [1:0][3:0]  barrier_trigger;
    logic [1:0][3:0]  barrier_events;
    logic [3:0]       core_clock_en;

    int checks = 0;
    int errors = 0;

    eu_barrier_wait_ctrl #(
        .NB_CORES  (4),
        .NB_BARR   (2),
        .TIMEOUT_W (TW)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .core_req_i        (core_req),
        .core_wen_i        (core_wen),
        .core_add_i        (core_add),
        .core_wdata_i      (core_wdata),
        .core_gnt_o        (core_gnt),
        .core_r_valid_o    (core_r_valid),
        .core_r_rdata_o    (core_r_rdata),
        .barrier_trigger_o (barrier_trigger),
        .barrier_events_i  (barrier_events),
        .core_clock_en_o   (core_clock_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic idle_inputs();
        core_req       = '0;
        core_wen       = '0;
        core_add       = '0;
        core_wdata     = '0;
        barrier_events = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (core_gnt !== 4'hF) begin errors++; $display("[TB] FAIL reset_gnt: got %h, expected %h", core_gnt, 4'hF); end
        checks++; if (core_r_valid !== 4'h0) begin errors++; $display("[TB] FAIL reset_rvalid: got %h, expected 0", core_r_valid); end
        checks++; if (core_r_rdata !== 128'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h, expected 0", core_r_rdata); end
        checks++; if (barrier_trigger !== 8'h00) begin errors++; $display("[TB] FAIL reset_trigger: got %h, expected 0", barrier_trigger); end
        checks++; if (core_clock_en !== 4'hF) begin errors++; $display("[TB] FAIL reset_clock_en: got %h, expected %h", core_clock_en, 4'hF); end
        rst_ni = 1'b1;
    endtask

    task automatic test_basic_wait();
        step(); core_req[0] = 1'b1; core_wen[0] = 1'b1; core_add[0] = 8'h00; #1;
        checks++; if (core_gnt[0] !== 1'b1) begin errors++; $display("[TB] FAIL basic_gnt: got %b, expected 1", core_gnt[0]); end
        step(); idle_inputs(); #1;
        checks++; if (barrier_trigger !== 8'h01) begin errors++; $display("[TB] FAIL basic_trigger: got %h, expected 01", barrier_trigger); end
        checks++; if (core_clock_en[0] !== 1'b1) begin errors++; $display("[TB] FAIL basic_trig_clk_en: got %b, expected 1", core_clock_en[0]); end
        for (int k = 2; k <= 5; k++) begin
            step(); if (k == 5) barrier_events[0][0] = 1'b1; #1;
            checks++; if (core_clock_en[0] !== 1'b0) begin errors++; $display("[TB] FAIL basic_sleep_clk_en t+%0d: got %b, expected 0", k, core_clock_en[0]); end
            checks++; if (barrier_trigger !== 8'h00) begin errors++; $display("[TB] FAIL basic_no_retrigger t+%0d: got %h, expected 0", k, barrier_trigger); end
            checks++; if (core_r_valid[0] !== 1'b0) begin errors++; $display("[TB] FAIL basic_early_rvalid t+%0d: got %b, expected 0", k, core_r_valid[0]); end
        end
        step(); idle_inputs(); #1;
        checks++; if (core_r_valid[0] !== 1'b1) begin errors++; $display("[TB] FAIL basic_rvalid: got %b, expected 1", core_r_valid[0]); end
        checks++; if (core_r_rdata[0] !== 32'h0) begin errors++; $display("[TB] FAIL basic_rdata: got %h, expected 0", core_r_rdata[0]); end
        checks++; if (core_clock_en[0] !== 1'b1) begin errors++; $display("[TB] FAIL basic_wake_clk_en: got %b, expected 1", core_clock_en[0]); end
        step(); #1;
        checks++; if (core_r_valid[0] !== 1'b0) begin errors++; $display("[TB] FAIL basic_rvalid_drop: got %b, expected 0", core_r_valid[0]); end
        checks++; if (core_gnt[0] !== 1'b1) begin errors++; $display("[TB] FAIL basic_back_idle: got %b, expected 1", core_gnt[0]); end
    endtask

    task automatic test_early_event();
        step(); barrier_events[1][2] = 1'b1; #1;
        step(); idle_inputs(); core_req[2] = 1'b1; core_wen[2] = 1'b1; core_add[2] = 8'hFC; #1;
        step(); core_add[2] = 8'h04; #1;
        checks++; if (core_r_valid[2] !== 1'b1) begin errors++; $display("[TB] FAIL early_mask_rvalid: got %b, expected 1", core_r_valid[2]); end
        checks++; if (core_r_rdata[2] !== 32'h2) begin errors++; $display("[TB] FAIL early_mask_before: got %h, expected 2", core_r_rdata[2]); end
        step(); idle_inputs(); #1;
        checks++; if (barrier_trigger !== 8'h40) begin errors++; $display("[TB] FAIL early_trigger: got %h, expected 40", barrier_trigger); end
        checks++; if (core_clock_en[2] !== 1'b1) begin errors++; $display("[TB] FAIL early_trig_clk_en: got %b, expected 1", core_clock_en[2]); end
        step(); #1;
        checks++; if (core_clock_en[2] !== 1'b0) begin errors++; $display("[TB] FAIL early_sleep_clk_en: got %b, expected 0", core_clock_en[2]); end
        checks++; if (core_r_valid[2] !== 1'b0) begin errors++; $display("[TB] FAIL early_rvalid_t2: got %b, expected 0", core_r_valid[2]); end
        step(); #1;
        checks++; if (core_r_valid[2] !== 1'b1) begin errors++; $display("[TB] FAIL early_rvalid_t3: got %b, expected 1", core_r_valid[2]); end
        checks++; if (core_r_rdata[2] !== 32'h1) begin errors++; $display("[TB] FAIL early_rdata: got %h, expected 1", core_r_rdata[2]); end
        checks++; if (core_clock_en[2] !== 1'b1) begin errors++; $display("[TB] FAIL early_wake_clk_en: got %b, expected 1", core_clock_en[2]); end
        step(); core_req[2] = 1'b1; core_wen[2] = 1'b1; core_add[2] = 8'hFC; #1;
        step(); idle_inputs(); #1;
        checks++; if (core_r_rdata[2] !== 32'h0 || core_r_valid[2] !== 1'b1) begin errors++; $display("[TB] FAIL early_mask_after: got valid %b data %h, expected valid 1 data 0", core_r_valid[2], core_r_rdata[2]); end
    endtask

    task automatic test_foreign_event();
        step(); core_req[1] = 1'b1; core_wen[1] = 1'b1; core_add[1] = 8'h00; #1;
        step(); idle_inputs(); #1;
        checks++; if (barrier_trigger !== 8'h02) begin errors++; $display("[TB] FAIL foreign_trigger: got %h, expected 02", barrier_trigger); end
        step(); #1;
        step(); barrier_events[1][1] = 1'b1; #1;
        step(); idle_inputs(); #1;
        checks++; if (core_clock_en[1] !== 1'b0 || core_r_valid[1] !== 1'b0) begin errors++; $display("[TB] FAIL foreign_still_sleep: got clk_en %b valid %b, expected 0 0", core_clock_en[1], core_r_valid[1]); end
        step(); #1;
        checks++; if (core_clock_en[1] !== 1'b0) begin errors++; $display("[TB] FAIL foreign_still_sleep2: got %b, expected 0", core_clock_en[1]); end
        step(); barrier_events[0][1] = 1'b1; #1;
        step(); idle_inputs(); #1;
        checks++; if (core_r_valid[1] !== 1'b1 || core_r_rdata[1] !== 32'h0) begin errors++; $display("[TB] FAIL foreign_wake: got valid %b data %h, expected 1 0", core_r_valid[1], core_r_rdata[1]); end
        step(); core_req[1] = 1'b1; core_wen[1] = 1'b1; core_add[1] = 8'hFC; #1;
        step(); idle_inputs(); #1;
        checks++; if (core_r_rdata[1] !== 32'h2) begin errors++; $display("[TB] FAIL foreign_pend_kept: got %h, expected 2", core_r_rdata[1]); end
    endtask

    task automatic test_clear_race();
        step(); barrier_events[0][3] = 1'b1; #1;
        step(); idle_inputs(); core_req[3] = 1'b1; core_wen[3] = 1'b0; core_add[3] = 8'hFC; core_wdata[3] = 32'h1; barrier_events[0][3] = 1'b1; #1;
        checks++; if (core_gnt[3] !== 1'b1) begin errors++; $display("[TB] FAIL race_gnt: got %b, expected 1", core_gnt[3]); end
        step(); idle_inputs(); core_req[3] = 1'b1; core_wen[3] = 1'b1; core_add[3] = 8'hFC; #1;
        checks++; if (core_r_valid[3] !== 1'b1 || core_r_rdata[3] !== 32'h0) begin errors++; $display("[TB] FAIL race_write_resp: got valid %b data %h, expected 1 0", core_r_valid[3], core_r_rdata[3]); end
        step(); idle_inputs(); #1;
        checks++; if (core_r_rdata[3] !== 32'h1) begin errors++; $display("[TB] FAIL race_set_wins: got %h, expected 1", core_r_rdata[3]); end
        step(); core_req[3] = 1'b1; core_wen[3] = 1'b0; core_add[3] = 8'hFC; core_wdata[3] = 32'h3; #1;
        step(); core_wen[3] = 1'b1; core_wdata[3] = 32'h0; #1;
        step(); idle_inputs(); #1;
        checks++; if (core_r_rdata[3] !== 32'h0) begin errors++; $display("[TB] FAIL clear_next_cycle: got %h, expected 0", core_r_rdata[3]); end
    endtask

    task automatic test_other_access();
        step(); barrier_events[1][0] = 1'b1; core_req[0] = 1'b1; core_wen[0] = 1'b1; core_add[0] = 8'h08; #1;
        checks++; if (core_gnt[0] !== 1'b1) begin errors++; $display("[TB] FAIL other_gnt: got %b, expected 1", core_gnt[0]); end
        step(); idle_inputs(); core_req[0] = 1'b1; core_wen[0] = 1'b0; core_add[0] = 8'h14; core_wdata[0] = 32'hFFFF_FFFF; #1;
        checks++; if (core_r_valid[0] !== 1'b1 || core_r_rdata[0] !== 32'h0) begin errors++; $display("[TB] FAIL other_read_zero: got valid %b data %h, expected 1 0", core_r_valid[0], core_r_rdata[0]); end
        checks++; if (barrier_trigger !== 8'h00 || core_clock_en[0] !== 1'b1) begin errors++; $display("[TB] FAIL other_no_wait: got trig %h clk_en %b, expected 00 1", barrier_trigger, core_clock_en[0]); end
        step(); core_wen[0] = 1'b1; core_add[0] = 8'hFC; core_wdata[0] = 32'h0; #1;
        step(); idle_inputs(); #1;
        checks++; if (core_r_rdata[0] !== 32'h2) begin errors++; $display("[TB] FAIL other_write_ignored: got %h, expected 2", core_r_rdata[0]); end
    endtask

    task automatic test_reset_in_sleep();
        step(); barrier_events[1][3] = 1'b1; core_req[0] = 1'b1; core_wen[0] = 1'b1; core_add[0] = 8'h00; #1;
        step(); idle_inputs(); #1;
        step(); #1;
        checks++; if (core_clock_en[0] !== 1'b0) begin errors++; $display("[TB] FAIL rst_pre_sleep: got %b, expected 0", core_clock_en[0]); end
        #2; rst_ni = 1'b0; #1;
        checks++; if (core_clock_en[0] !== 1'b1) begin errors++; $display("[TB] FAIL rst_async_clk_en: got %b, expected 1", core_clock_en[0]); end
        checks++; if (core_gnt !== 4'hF || core_r_valid !== 4'h0) begin errors++; $display("[TB] FAIL rst_async_state: got gnt %h valid %h, expected F 0", core_gnt, core_r_valid); end
        step(); step(); rst_ni = 1'b1; #1;
        step(); core_req[3] = 1'b1; core_wen[3] = 1'b1; core_add[3] = 8'hFC; #1;
        checks++; if (core_r_valid[0] !== 1'b0 || core_clock_en !== 4'hF) begin errors++; $display("[TB] FAIL rst_no_resp: got valid %b clk_en %h, expected 0 F", core_r_valid[0], core_clock_en); end
        step(); idle_inputs(); #1;
        checks++; if (core_r_rdata[3] !== 32'h0) begin errors++; $display("[TB] FAIL rst_pend_cleared: got %h, expected 0", core_r_rdata[3]); end
        step(); core_req[0] = 1'b1; core_wen[0] = 1'b1; core_add[0] = 8'h04; #1;
        step(); idle_inputs(); #1;
        checks++; if (barrier_trigger !== 8'h10) begin errors++; $display("[TB] FAIL post_rst_trigger: got %h, expected 10", barrier_trigger); end
        step(); barrier_events[1][0] = 1'b1; #1;
        checks++; if (core_clock_en[0] !== 1'b0) begin errors++; $display("[TB] FAIL post_rst_sleep: got %b, expected 0", core_clock_en[0]); end
        step(); idle_inputs(); #1;
        checks++; if (core_r_valid[0] !== 1'b1 || core_r_rdata[0] !== 32'h1) begin errors++; $display("[TB] FAIL post_rst_min_latency: got valid %b data %h, expected 1 1", core_r_valid[0], core_r_rdata[0]); end
    endtask

`ifdef BARRIER_WAIT_TIMEOUT_EN
    task automatic test_timeout();
        step(); core_req[0] = 1'b1; core_wen[0] = 1'b1; core_add[0] = 8'h04; #1;
        step(); idle_inputs(); #1;
        for (int k = 2; k <= 17; k++) begin
            step(); #1;
        end
        checks++; if (core_r_valid[0] !== 1'b0 || core_clock_en[0] !== 1'b0) begin errors++; $display("[TB] FAIL timeout_early: got valid %b clk_en %b, expected 0 0", core_r_valid[0], core_clock_en[0]); end
        step(); #1;
        checks++; if (core_r_valid[0] !== 1'b1 || core_r_rdata[0] !== 32'h8000_0001) begin errors++; $display("[TB] FAIL timeout_resp: got valid %b data %h, expected 1 80000001", core_r_valid[0], core_r_rdata[0]); end
    endtask
`endif

    initial begin
        rst_ni = 1'b0;
        idle_inputs();
        test_reset();
        test_basic_wait();
        test_early_event();
        test_foreign_event();
        test_clear_race();
        test_other_access();
        test_reset_in_sleep();
`ifdef BARRIER_WAIT_TIMEOUT_EN
        test_timeout();
`endif
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
